pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MULDIV_LAT, default 4, meaning the EXE occupancy in cycles of a multiply/divide; legal range 2..15.
REQ-002 Parameter CNT_W, default 16, meaning the stall-counter width.
REQ-003 Clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 MemRead_EXE  input  1  meaning the instruction in EXE is a load.
REQ-006 RegWr_EXE  input  5  meaning the destination register of the instruction in EXE.
REQ-007 Rs_ID, Rt_ID  input  5 each  meaning the source registers of the instruction in ID.
REQ-008 UsesRt_ID  input  1  meaning the ID instruction reads Rt.
REQ-009 Branch_taken_EXE  input  1  meaning a branch or jump resolved taken in EXE this cycle.
REQ-010 MulDiv_start_EXE  input  1  meaning a multiply/divide entered EXE this cycle.
REQ-011 Halt_ID  input  1  meaning a halt instruction is decoded in ID.
REQ-012 Stall_cnt_clr  input  1  meaning synchronous clear of Stall_count.
REQ-013 PC_Write, IF_ID_Write, ID_EXE_Write  output  1 each  meaning the pipeline register enables.
REQ-014 ID_EXE_Bubble, EXE_MEM_Bubble  output  1 each  meaning insert a NOP into the named register.
REQ-015 IF_ID_Flush, ID_EXE_Flush  output  1 each  meaning zero the named register.
REQ-016 MulDiv_done  output  1  meaning one-cycle pulse on the last busy cycle.
REQ-017 Halted  output  1  meaning the pipeline is halted.
REQ-018 Stall_count  output  CNT_W  meaning the number of stall cycles seen.

Function
REQ-019 The FSM SHALL have the states RUN, MD_BUSY and HALTED; outputs SHALL be combinational from the state and the current inputs.
REQ-020 LU SHALL be defined as MemRead_EXE && RegWr_EXE!=0 && (RegWr_EXE==Rs_ID || (UsesRt_ID && RegWr_EXE==Rt_ID)).
REQ-021 Default in RUN SHALL be: all Write enables 1, all Bubble/Flush outputs 0, MulDiv_done 0.
REQ-022 Priority in RUN SHALL be Branch_taken_EXE > MulDiv_start_EXE > LU > Halt_ID.
REQ-023 RUN with Branch_taken_EXE SHALL give IF_ID_Flush=1 and ID_EXE_Flush=1 in the same cycle; LU and Halt_ID SHALL be ignored; the next state SHALL be RUN.
REQ-024 RUN with MulDiv_start_EXE (no branch) SHALL load the busy counter with MULDIV_LAT-1, and the next state SHALL be MD_BUSY.
REQ-025 On the start cycle, the enables SHALL stay 1 (the instruction occupies EXE).
REQ-026 MD_BUSY SHALL give PC_Write=0, IF_ID_Write=0, ID_EXE_Write=0 and EXE_MEM_Bubble=1; the counter SHALL decrement each cycle.
REQ-027 MD_BUSY SHALL ignore Branch_taken_EXE, LU and MulDiv_start_EXE.
REQ-028 When the MD_BUSY counter is 1, MulDiv_done=1, and the next state SHALL be RUN.
REQ-029 The total stall SHALL therefore be exactly MULDIV_LAT-1 cycles.
REQ-030 RUN with LU (no branch or muldiv) SHALL give PC_Write=0, IF_ID_Write=0 and ID_EXE_Bubble=1 for that cycle only; the state SHALL stay RUN.
REQ-031 Back-to-back LU SHALL stall once per qualifying cycle.
REQ-032 RUN with Halt_ID and no higher-priority event SHALL move the next state to HALTED.
REQ-033 HALTED SHALL give PC_Write=0, IF_ID_Write=0 and ID_EXE_Bubble=1, with Halted=1.
REQ-034 HALTED SHALL be exited only by reset.
REQ-035 Stall_count SHALL increment by 1 on every cycle with PC_Write=0 while not HALTED, and SHALL saturate at all-ones.
REQ-036 Stall_cnt_clr SHALL zero Stall_count and SHALL take priority over a simultaneous increment.
REQ-037 RegWr_EXE==0 SHALL never produce LU.

Reset
REQ-038 Rst_n low SHALL force state RUN, busy counter 0 and Stall_count 0 asynchronously.
REQ-039 During reset, the outputs SHALL take the RUN defaults: enables 1, Halted 0, MulDiv_done 0.
REQ-040 Reset asserted in MD_BUSY or HALTED SHALL abort immediately; no MulDiv_done pulse SHALL be issued.

Structure
REQ-041 State encodings (RUN=2'b00, MD_BUSY=2'b01, HALTED=2'b10) and the MULDIV_LAT default SHALL reside in the shared pipeline constants package.
REQ-042 The load-use comparator SHALL be a sub-module named load_use_detector; the FSM and counters SHALL stay in the top module.

Verification
REQ-043 Load-use: MemRead_EXE=1, RegWr_EXE=5, Rs_ID=5 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EXE_Bubble=1; Stall_count=1.
REQ-044 No load-use: same as REQ-043 with RegWr_EXE=0, or with Rt_ID=5 and UsesRt_ID=0 -> no stall.
REQ-045 MulDiv: MulDiv_start_EXE pulse with MULDIV_LAT=4 -> MD_BUSY for 3 cycles, MulDiv_done on the 3rd, then RUN; Stall_count=3.
REQ-046 Branch priority: Branch_taken_EXE=1 with LU=1 -> both Flush outputs 1, PC_Write=1, no bubble.
REQ-047 Halt: Halt_ID=1 -> Halted=1 from the next cycle and persists; Rst_n pulse low -> RUN, Stall_count=0.
REQ-048 Saturation and clear: CNT_W=2 with 5 stall cycles -> Stall_count=3; Stall_cnt_clr together with a stall -> 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline constants: hazard FSM state encoding and multiply/divide latency default.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MD_BUSY = 2'b01,
    ST_HALTED  = 2'b10
  } hz_state_t;

  localparam int unsigned MULDIV_LAT_DEFAULT = 4;
  // Wide enough for the largest legal latency (15).
  localparam int unsigned BUSY_W = 4;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Load-use comparator: flags an ID source register produced by a load still in EXE.
module load_use_detector (
  input  logic       mem_read_exe,
  input  logic [4:0] reg_wr_exe,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  output logic       load_use
);

  logic dest_valid_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign dest_valid_s = (reg_wr_exe != 5'd0);
  assign rs_hit_s     = (reg_wr_exe == rs_id);
  assign rt_hit_s     = uses_rt_id && (reg_wr_exe == rt_id);
  assign load_use     = mem_read_exe && dest_valid_s && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle mul/div stall,
// halt, and a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_exe,
  input  logic [4:0]       reg_wr_exe,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             branch_taken_exe,
  input  logic             muldiv_start_exe,
  input  logic             halt_id,
  input  logic             stall_cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_exe_write,
  output logic             id_exe_bubble,
  output logic             exe_mem_bubble,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             muldiv_done,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MULDIV_LAT - 1);

  hz_state_t         state_r, state_next_s;
  logic [BUSY_W-1:0] busy_cnt_r, busy_cnt_next_s;
  logic [CNT_W-1:0]  stall_count_r;
  logic              lu_s;

  load_use_detector u_lu (
    .mem_read_exe (mem_read_exe),
    .reg_wr_exe   (reg_wr_exe),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .uses_rt_id   (uses_rt_id),
    .load_use     (lu_s)
  );

  // State and busy-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      busy_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      busy_cnt_r <= busy_cnt_next_s;
    end
  end

  // Next-state and pipeline-control decode; reset holds the RUN defaults on the outputs.
  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    id_exe_write    = 1'b1;
    id_exe_bubble   = 1'b0;
    exe_mem_bubble  = 1'b0;
    if_id_flush     = 1'b0;
    id_exe_flush    = 1'b0;
    muldiv_done     = 1'b0;
    halted          = 1'b0;
    state_next_s    = state_r;
    busy_cnt_next_s = busy_cnt_r;
    if (!rst_n) begin
      state_next_s    = ST_RUN;
      busy_cnt_next_s = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (branch_taken_exe) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
          end else if (muldiv_start_exe) begin
            busy_cnt_next_s = BUSY_LOAD;
            state_next_s    = ST_MD_BUSY;
          end else if (lu_s) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
          end else if (halt_id) begin
            state_next_s = ST_HALTED;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_MD_BUSY: begin
          pc_write        = 1'b0;
          if_id_write     = 1'b0;
          id_exe_write    = 1'b0;
          exe_mem_bubble  = 1'b1;
          busy_cnt_next_s = busy_cnt_r - BUSY_W'(1);
          // A zero count cannot occur here normally; treat it as finished rather than wrap.
          if (busy_cnt_r <= BUSY_W'(1)) begin
            muldiv_done     = 1'b1;
            busy_cnt_next_s = '0;
            state_next_s    = ST_RUN;
          end else begin
            state_next_s = ST_MD_BUSY;
          end
        end
        ST_HALTED: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_exe_bubble = 1'b1;
          halted        = 1'b1;
          state_next_s  = ST_HALTED;
        end
        default: begin
          state_next_s    = ST_RUN;
          busy_cnt_next_s = '0;
        end
      endcase
    end
  end

  // Saturating stall counter; cycles spent halted are not stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= '0;
    end else if (stall_cnt_clr) begin
      stall_count_r <= '0;
    end else if (!pc_write && (state_r != ST_HALTED) && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + CNT_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: two controller instances (default, and LAT=2/CNT_W=2) driven with
// directed and random stimulus against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read_exe;
  logic [4:0] reg_wr_exe, rs_id, rt_id;
  logic       uses_rt_id, branch_taken_exe, muldiv_start_exe, halt_id, stall_cnt_clr;

  logic [8:0]  ctl [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  // Model state, per instance: remaining busy cycles, halted flag, unbounded stall count.
  int m_busy [2];
  bit m_halt [2];
  int m_cnt  [2];
  int lat    [2] = '{4, 2};
  int cmax   [2] = '{65535, 3};

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULDIV_LAT(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read_exe(mem_read_exe), .reg_wr_exe(reg_wr_exe),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id), .branch_taken_exe(branch_taken_exe),
    .muldiv_start_exe(muldiv_start_exe), .halt_id(halt_id), .stall_cnt_clr(stall_cnt_clr),
    .pc_write(ctl[0][8]), .if_id_write(ctl[0][7]), .id_exe_write(ctl[0][6]),
    .id_exe_bubble(ctl[0][5]), .exe_mem_bubble(ctl[0][4]), .if_id_flush(ctl[0][3]),
    .id_exe_flush(ctl[0][2]), .muldiv_done(ctl[0][1]), .halted(ctl[0][0]), .stall_count(cnt0)
  );

  pipeline_hazard_controller #(.MULDIV_LAT(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read_exe(mem_read_exe), .reg_wr_exe(reg_wr_exe),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id), .branch_taken_exe(branch_taken_exe),
    .muldiv_start_exe(muldiv_start_exe), .halt_id(halt_id), .stall_cnt_clr(stall_cnt_clr),
    .pc_write(ctl[1][8]), .if_id_write(ctl[1][7]), .id_exe_write(ctl[1][6]),
    .id_exe_bubble(ctl[1][5]), .exe_mem_bubble(ctl[1][4]), .if_id_flush(ctl[1][3]),
    .id_exe_flush(ctl[1][2]), .muldiv_done(ctl[1][1]), .halted(ctl[1][0]), .stall_count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit lu_ref();
    return mem_read_exe && (reg_wr_exe != 5'd0) &&
           ((reg_wr_exe == rs_id) || (uses_rt_id && (reg_wr_exe == rt_id)));
  endfunction

  // Expected {pc,ifid,idexe,id_bub,em_bub,if_fl,id_fl,done,halted} for instance k.
  function automatic logic [8:0] exp_ctl(input int k);
    logic [8:0] e;
    e = 9'b111_000000;
    if (!rst_n)          e = 9'b111_000000;
    else if (m_halt[k])  e = 9'b001_100001;
    else if (m_busy[k] > 0) e = {8'b000_01000, 1'b0} | ((m_busy[k] == 1) ? 9'b000_000010 : 9'b0);
    else if (branch_taken_exe) e = 9'b111_001100;
    else if (muldiv_start_exe) e = 9'b111_000000;
    else if (lu_ref())   e = 9'b001_100000;
    else                 e = 9'b111_000000;
    return e;
  endfunction

  function automatic int sat(input int k);
    return (m_cnt[k] > cmax[k]) ? cmax[k] : m_cnt[k];
  endfunction

  // Called at a negedge with inputs applied: check, advance the model, wait one cycle.
  task automatic step();
    logic [8:0] e [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_halt[k] = 1'b0; m_cnt[k] = 0;
      end
      e[k] = exp_ctl(k);
      check($sformatf("ctl%0d", k), {23'd0, ctl[k]}, {23'd0, e[k]});
    end
    check("cnt0", {16'd0, cnt0}, sat(0));
    check("cnt1", {30'd0, cnt1}, sat(1));
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        if (stall_cnt_clr) m_cnt[k] = 0;
        else if (!e[k][8] && !m_halt[k]) m_cnt[k]++;
        if (m_halt[k]) ;
        else if (m_busy[k] > 0) m_busy[k]--;
        else if (branch_taken_exe) ;
        else if (muldiv_start_exe) m_busy[k] = lat[k] - 1;
        else if (lu_ref()) ;
        else if (halt_id) m_halt[k] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit mr, input int rd, input int rs, input int rt, input bit ur,
                       input bit br, input bit md, input bit hl, input bit clr);
    mem_read_exe = mr; reg_wr_exe = 5'(rd); rs_id = 5'(rs); rt_id = 5'(rt); uses_rt_id = ur;
    branch_taken_exe = br; muldiv_start_exe = md; halt_id = hl; stall_cnt_clr = clr;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0);    // load-use visible during reset: must be ignored
    @(negedge clk);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("lu_cnt", {16'd0, cnt0}, 32'd1);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);    // destination r0
    step();
    drive(1, 5, 1, 5, 0, 0, 0, 0, 0);    // Rt match but Rt unused
    step();
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0);    // Rt match and used
    step();
    drive(1, 5, 5, 5, 1, 1, 0, 1, 0);    // branch beats load-use and halt
    step();
    base = cnt0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 5, 5, 0, 0, 1, 1, 0, 0);    // ignored while busy
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("md_stall", cnt0 - 16'(base), 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 7, 7, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    check("sat_cnt1", {30'd0, cnt1}, 32'd3);
    drive(1, 7, 7, 0, 0, 0, 0, 0, 1);    // clear wins over stall
    step();
    check("clr_cnt0", {16'd0, cnt0}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 3, 3, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step();
    check("halted", {31'd0, ctl[0][0]}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;                        // abort mid multiply/divide
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
